// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and data-memory port A.
// Stores take one write cycle; loads issue 1..4 consecutive word reads.
module mem_access_unit #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_len,
    output logic              req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              wr_done,
    output logic              stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic              wr_done_q, wr_done_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        wr_done_d = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        req_ready = (state_q == S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        wdata_d = req_wdata;
                        state_d = S_STORE;
                    end else begin
                        len_d   = req_len;
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_STORE: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                wr_done_d = 1'b1;
                state_d   = S_DRAIN;
            end
            S_LOAD: begin
                // Address adds wrap naturally at the port width
                mem_addr = addr_q + ADDR_W'(cnt_q);
                rvalid_d = 1'b1;
                if (cnt_q == len_q) begin
                    rlast_d = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            wr_done_q <= wr_done_d;
        end
    end

    assign resp_valid = rvalid_q;
    assign resp_last  = rlast_q;
    assign resp_data  = rvalid_q ? mem_rdata : '0;
    assign wr_done    = wr_done_q;
    assign stall      = ~req_ready;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 19, SHALL set the width of data-memory word addresses.
REQ-002 Parameter DATA_W, default 24, SHALL set the width of data-memory words.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid  in  1  SHALL indicate that the pipeline presents a memory request.
REQ-007 req_write  in  1  SHALL select the request type: 1 = store, 0 = load.
REQ-008 req_addr  in  ADDR_W  SHALL be the base word address.
REQ-009 req_wdata  in  DATA_W  SHALL be the store data.
REQ-010 req_len  in  2  SHALL give the load burst length minus 1 (1..4 beats); stores SHALL ignore it.
REQ-011 req_ready  out  1  SHALL be high only in IDLE; a request is accepted when req_valid & req_ready.
REQ-012 mem_addr  out  ADDR_W  SHALL drive the data-memory port-A address.
REQ-013 mem_wdata  out  DATA_W  SHALL drive the data-memory port-A write data.
REQ-014 mem_write  out  1  SHALL be the data-memory write strobe.
REQ-015 mem_rdata  in  DATA_W  SHALL be the data-memory port-A read data, valid 1 cycle after its address.
REQ-016 resp_valid  out  1  SHALL mark a load beat on resp_data.
REQ-017 resp_data  out  DATA_W  SHALL carry the load data.
REQ-018 resp_last  out  1  SHALL mark the final beat of a burst.
REQ-019 wr_done  out  1  SHALL pulse for 1 cycle when a store has been issued.
REQ-020 stall  out  1  SHALL equal ~req_ready, and SHALL freeze the upstream pipeline stage.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, STORE, LOAD, DRAIN.
REQ-022 In IDLE, an accepted store SHALL latch the address and data and enter STORE.
REQ-023 In IDLE, an accepted load SHALL latch the address, set beats = req_len+1, clear the issue counter, and enter LOAD.
REQ-024 STORE SHALL last exactly 1 cycle: mem_write=1, mem_addr=latched addr, mem_wdata=latched data.
REQ-025 wr_done SHALL assert in the cycle after STORE, and the FSM SHALL return to IDLE.
REQ-026 In LOAD, mem_addr SHALL be base+i in cycle i (i = 0..beats-1), with mem_write=0.
REQ-027 LOAD SHALL last exactly beats cycles and then enter DRAIN.
REQ-028 DRAIN SHALL last 1 cycle and then return to IDLE.
REQ-029 resp_valid SHALL be high exactly 1 cycle after each LOAD issue cycle, giving exactly beats pulses.
REQ-030 While resp_valid is high, resp_data SHALL equal mem_rdata.
REQ-031 resp_last SHALL be high only together with the beat issued in the final LOAD cycle (the DRAIN cycle).
REQ-032 Load latency SHALL be: acceptance at cycle 0, first address at cycle 1, first resp_valid at cycle 2, last resp_valid at cycle beats+1.
REQ-033 Burst address arithmetic SHALL be modulo 2^ADDR_W; 0x7FFFF+1 SHALL wrap to 0x00000.
REQ-034 The block SHALL NOT decode address regions; IO and main-memory selection belong downstream.
REQ-035 The response path SHALL have no backpressure; the consumer SHALL accept every beat.
REQ-036 Outside STORE and LOAD, mem_addr, mem_wdata and mem_write SHALL be 0.
REQ-037 In IDLE, resp_valid and resp_last SHALL be 0 except for the trailing beat of a completing burst.
REQ-038 Requests presented while req_ready=0 SHALL be ignored; upstream SHALL hold them until accepted.
REQ-039 Back-to-back requests SHALL be supported: a new request SHALL be acceptable in the first IDLE cycle after DRAIN or STORE.

Reset
REQ-040 rst SHALL force IDLE and set all outputs to 0 except req_ready=1.
REQ-041 rst SHALL clear the burst counter, the beat count and the response-valid pipeline register.
REQ-042 rst asserted mid-burst SHALL produce no resp_valid from the cycle after rst onward.
REQ-043 rst asserted during STORE SHALL suppress wr_done.

Verification
REQ-044 Store test: store addr 0x00100, data 0xABCDEF -> mem_write=1 for exactly 1 cycle with mem_addr=0x00100 and mem_wdata=0xABCDEF; wr_done 1 cycle later; req_ready low for exactly 2 cycles.
REQ-045 Single-load test: load addr 0x00100, len 0, memory model returns 0xABCDEF -> exactly one resp_valid, with resp_last=1 and resp_data=0xABCDEF, 2 cycles after acceptance.
REQ-046 Burst test: load addr 0x00010, len 3 -> mem_addr = 0x10, 0x11, 0x12, 0x13 on consecutive cycles; 4 resp_valid beats; resp_last only on the 4th; req_ready returns after 5 cycles.
REQ-047 Wrap test: load addr 0x7FFFE, len 3 -> addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-048 Reset test: rst asserted after the 2nd beat of a 4-beat burst -> no further resp_valid; next cycle shows req_ready=1 and all memory outputs 0.
REQ-049 Back-to-back test: a store request held during a burst -> accepted in the first IDLE cycle only; its mem_write never overlaps a LOAD address cycle.
